// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution row scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int DEF_D     = 1;
  localparam int DEF_H     = 32;
  localparam int DEF_W     = 32;
  localparam int DEF_F     = 5;
  localparam int OH        = DEF_H - DEF_F + 1;
  localparam int OW        = DEF_W - DEF_F + 1;
  localparam int DEF_UNITS = OW / 2;
  localparam int G         = ceil_div(OW, DEF_UNITS);
  localparam int TAPS      = DEF_D * DEF_F * DEF_F;

endpackage

// File: rtl/conv_pos_counter.sv
// Output-map position stepping: row / column-group base with a last-group flag.
module conv_pos_counter #(
  parameter int OH        = 28,
  parameter int OW        = 28,
  parameter int NUM_UNITS = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [5:0] o_row,
  output logic [5:0] o_col_base,
  output logic       o_last
);

  logic [5:0] r_row;
  logic [5:0] r_col_base;
  logic [6:0] w_col_sum;
  logic       w_row_last;
  logic       w_col_last;

  assign w_col_sum  = {1'b0, r_col_base} + 7'(NUM_UNITS);
  assign w_col_last = (w_col_sum >= 7'(OW));
  assign w_row_last = (r_row == 6'(OH - 1));
  assign o_last     = w_row_last && w_col_last;

  // The final group does not advance so the last-written position stays visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row      <= '0;
      r_col_base <= '0;
    end else if (i_clear) begin
      r_row      <= '0;
      r_col_base <= '0;
    end else if (i_advance && !o_last) begin
      if (w_col_last) begin
        r_col_base <= '0;
        r_row      <= r_row + 6'(1);
      end else begin
        r_col_base <= w_col_sum[5:0];
      end
    end
  end

  assign o_row      = r_row;
  assign o_col_base = r_col_base;

endmodule

// File: rtl/conv_row_scheduler.sv
// Layer sequencer for a bank of parallel conv units: clear, accumulate taps, drain, write per group.
// Optional CONV_SCHED_PERF_EN adds a perf_stall counter of WRITE cycles spent waiting on out_ready.
module conv_row_scheduler
  import conv_pkg::*;
#(
  parameter int D         = DEF_D,
  parameter int H         = DEF_H,
  parameter int W         = DEF_W,
  parameter int F         = DEF_F,
  parameter int NUM_UNITS = (W - F + 1) / 2,
  parameter int PIPE      = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [5:0]                         row,
  output logic [5:0]                         col_base,
  output logic                               cu_clear,
  output logic                               cu_en,
  output logic [clog2_min1(D*F*F)-1:0]       tap,
  output logic                               out_valid,
  input  logic                               out_ready
`ifdef CONV_SCHED_PERF_EN
  ,output logic [15:0]                       perf_stall
`endif
);

  localparam int OH_N   = H - F + 1;
  localparam int OW_N   = W - F + 1;
  localparam int TAPS_N = D * F * F;
  localparam int TAP_W  = clog2_min1(TAPS_N);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(TAPS_N - 1);
  localparam logic [7:0]       DRAIN_LAST = 8'((PIPE > 0) ? (PIPE - 1) : 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [TAP_W-1:0] r_tap;
  logic [7:0]       r_drain;
  logic             w_accept;
  logic             w_advance;
  logic             w_last;

  conv_pos_counter #(
    .OH        (OH_N),
    .OW        (OW_N),
    .NUM_UNITS (NUM_UNITS)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_accept),
    .i_advance  (w_advance),
    .o_row      (row),
    .o_col_base (col_base),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    cu_clear     = 1'b0;
    cu_en        = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        busy         = 1'b1;
        cu_clear     = 1'b1;
        w_state_next = ACCUM;
      end
      ACCUM: begin
        busy  = 1'b1;
        cu_en = 1'b1;
        if (r_tap == TAP_LAST) w_state_next = (PIPE == 0) ? WRITE : DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain == DRAIN_LAST) w_state_next = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? FIN : CLEAR;
        end
      end
      FIN: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Tap and drain counters sit at zero outside their own state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tap   <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == ACCUM && r_tap != TAP_LAST) r_tap <= r_tap + TAP_W'(1);
      else                                        r_tap <= '0;
      if (r_state == DRAIN && r_drain != DRAIN_LAST) r_drain <= r_drain + 8'(1);
      else                                           r_drain <= '0;
    end
  end

  assign tap = r_tap;

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_stall <= '0;
    end else if (r_state == WRITE && !out_ready && r_perf_stall != 16'hFFFF) begin
      r_perf_stall <= r_perf_stall + 16'(1);
    end
  end

  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler: default 32x32/F=5 instance plus a small 8x8/F=3 instance.
module tb_conv_row_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [5:0] row;
  logic [5:0] col_base;
  logic       cu_clear;
  logic       cu_en;
  logic [4:0] tap;
  logic       out_valid;

  logic       s_start;
  logic       s_ready;
  logic       s_busy;
  logic       s_done;
  logic [5:0] s_row;
  logic [5:0] s_col_base;
  logic       s_cu_clear;
  logic       s_cu_en;
  logic [3:0] s_tap;
  logic       s_out_valid;

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] s_perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  conv_row_scheduler u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .row       (row),
    .col_base  (col_base),
    .cu_clear  (cu_clear),
    .cu_en     (cu_en),
    .tap       (tap),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CONV_SCHED_PERF_EN
    ,.perf_stall (perf_stall)
`endif
  );

  conv_row_scheduler #(.H(8), .W(8), .F(3), .NUM_UNITS(4)) u_small (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .busy      (s_busy),
    .done      (s_done),
    .row       (s_row),
    .col_base  (s_col_base),
    .cu_clear  (s_cu_clear),
    .cu_en     (s_cu_en),
    .tap       (s_tap),
    .out_valid (s_out_valid),
    .out_ready (s_ready)
`ifdef CONV_SCHED_PERF_EN
    ,.perf_stall (s_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full layer on the default instance; cycle 1 is the first cycle after start is accepted.
  task automatic run_layer(input int stall_n, input int poke_at, output int done_c, output int n_writes);
    int         c;
    int         stall_left;
    logic [5:0] hold_row;
    logic [5:0] hold_col;
    hold_row   = '0;
    hold_col   = '0;
    done_c     = -1;
    n_writes   = 0;
    stall_left = stall_n;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    c     = 1;
    chk("accept_busy", busy, 1);
    chk("accept_row0", row, 0);
    chk("accept_col0", col_base, 0);
    while (c < 3000) begin
      start = (c == poke_at);
      if (c <= 29) begin
        chk($sformatf("g0_clear@%0d", c), cu_clear, (c == 1));
        chk($sformatf("g0_en@%0d", c), cu_en, (c >= 2 && c <= 26));
        if (c >= 2 && c <= 26) chk($sformatf("g0_tap@%0d", c), tap, c - 2);
        chk($sformatf("g0_valid@%0d", c), out_valid, (c == 29));
      end
      if (out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (stall_left == stall_n) begin
            hold_row = row;
            hold_col = col_base;
            chk("stall_row0", row, 0);
            chk("stall_col0", col_base, 0);
          end else begin
            chk("stall_row_hold", row, hold_row);
            chk("stall_col_hold", col_base, hold_col);
          end
          stall_left--;
        end else begin
          out_ready = 1'b1;
          chk($sformatf("slot%0d", n_writes), row * 2 + col_base / 14, n_writes);
          n_writes++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_c = c;
        chk("done_busy_low", busy, 0);
        chk("fin_row_hold", row, 27);
        chk("fin_col_hold", col_base, 14);
        if (poke_at >= 0) start = 1'b1;
        break;
      end
      tick();
      c++;
    end
    if (done_c < 0) chk("layer_timeout", done, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_fin_busy%0d", i), busy, 0);
      chk($sformatf("post_fin_done%0d", i), done, 0);
      tick();
    end
  endtask

  initial begin
    int done_c;
    int n_wr;
    int c;
    int k;
    bit found;

    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    s_start   = 1'b0;
    s_ready   = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", cu_clear, 0);
    chk("rst_en", cu_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col_base, 0);
    chk("rst_tap", tap, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_busy", busy, 0);

    // Plain layer with out_ready high.
    run_layer(0, -1, done_c, n_wr);
    chk("l1_done_cycle", done_c, 1625);
    chk("l1_writes", n_wr, 56);

    // Ten-cycle stall on the first write.
    run_layer(10, -1, done_c, n_wr);
    chk("l2_done_cycle", done_c, 1635);
    chk("l2_writes", n_wr, 56);
`ifdef CONV_SCHED_PERF_EN
    chk("l2_perf_stall", perf_stall, 10);
`endif

    // Start pokes while busy and during FIN are ignored, then a clean re-run.
    run_layer(0, 100, done_c, n_wr);
    chk("l3_done_cycle", done_c, 1625);
    chk("l3_writes", n_wr, 56);
    run_layer(0, -1, done_c, n_wr);
    chk("l4_done_cycle", done_c, 1625);
`ifdef CONV_SCHED_PERF_EN
    chk("l4_perf_cleared", perf_stall, 0);
`endif

    // Reset in the middle of ACCUM on row 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (row == 7 && cu_en && tap == 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("r5_reach_row7", found, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("r5_busy", busy, 0);
    chk("r5_en", cu_en, 0);
    chk("r5_clear", cu_clear, 0);
    chk("r5_valid", out_valid, 0);
    chk("r5_done", done, 0);
    chk("r5_row", row, 0);
    chk("r5_col", col_base, 0);
    chk("r5_tap", tap, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("r5_no_done%0d", i), done, 0);
      chk($sformatf("r5_idle%0d", i), busy, 0);
    end
    run_layer(0, -1, done_c, n_wr);
    chk("l5_done_cycle", done_c, 1625);
    chk("l5_writes", n_wr, 56);

    // Small instance: OW=6, four units, two groups per row, 13 cycles per group.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    c = 1;
    k = 0;
    while (c < 400 && !s_done) begin
      if (s_out_valid) begin
        chk($sformatf("small_row%0d", k), s_row, k / 2);
        chk($sformatf("small_col%0d", k), s_col_base, (k % 2) * 4);
        k++;
      end
      tick();
      c++;
    end
    chk("small_done", s_done, 1);
    chk("small_done_cycle", c, 157);
    chk("small_writes", k, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
